// File: rtl/minimig_autoconfig_ctrl.sv
// Autoconfig protocol engine: serves config-space reads from the per-board
// nybble ROM page, latches base writes and walks Z2 RAM, Z3 RAM, ETH in turn.
module minimig_autoconfig_ctrl #(
    parameter int unsigned ACK_DELAY = 0
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [2:0]  board_en,
    input  logic        cpu_sel,
    input  logic        cpu_rd,
    input  logic        cpu_wr,
    input  logic [6:0]  cpu_addr,
    input  logic [15:0] cpu_din,
    output logic [15:0] cpu_dout,
    output logic        cpu_ack,
    output logic [7:0]  rom_addr,
    input  logic [3:0]  rom_q,
    output logic [7:0]  z2_base,
    output logic [15:0] z3_base,
    output logic [15:0] eth_base,
    output logic [2:0]  board_cfg,
    output logic        config_done
);

    typedef enum logic [2:0] {
        SCAN, IDLE, RD_WAIT, RD_DATA, WR, ACK, DONE
    } state_t;

    localparam logic [1:0] DLY = 2'(ACK_DELAY);

    state_t     state;
    logic [1:0] board_idx;
    logic [1:0] dly;
    logic       adv;
    logic [1:0] first_en;
    logic [3:0] en_ext;
    logic [7:0] offset;

    assign en_ext = {1'b0, board_en};
    assign offset = {cpu_addr, 1'b0};

    always_comb begin
        first_en = 2'd3;
        if (board_en[2]) first_en = 2'd2;
        if (board_en[1]) first_en = 2'd1;
        if (board_en[0]) first_en = 2'd0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= SCAN;
            board_idx   <= first_en;
            dly         <= 2'd0;
            adv         <= 1'b0;
            rom_addr    <= 8'h00;
            cpu_dout    <= 16'hFFFF;
            cpu_ack     <= 1'b0;
            z2_base     <= 8'h00;
            z3_base     <= 16'h0000;
            eth_base    <= 16'h0000;
            board_cfg   <= 3'b000;
            config_done <= (board_en == 3'b000);
        end else begin
            cpu_ack <= 1'b0;
            case (state)
                SCAN: begin
                    if (board_idx == 2'd3) begin
                        config_done <= 1'b1;
                        state       <= DONE;
                    end else if (!en_ext[board_idx]) begin
                        board_idx <= board_idx + 2'd1;
                    end else begin
                        state <= IDLE;
                    end
                end
                IDLE, DONE: begin
                    dly <= 2'd0;
                    adv <= 1'b0;
                    if (cpu_sel && cpu_rd) begin
                        rom_addr <= {board_idx, cpu_addr[5:0]};
                        state    <= RD_WAIT;
                    end else if (cpu_sel && cpu_wr) begin
                        state <= WR;
                    end
                end
                RD_WAIT: state <= RD_DATA;
                RD_DATA: begin
                    cpu_dout <= {rom_q, 12'hFFF};
                    if (dly == DLY) begin
                        cpu_ack <= 1'b1;
                        state   <= ACK;
                    end else begin
                        dly <= dly + 2'd1;
                    end
                end
                WR: begin
                    if (dly == DLY) begin
                        cpu_ack <= 1'b1;
                        state   <= ACK;
                        // board 3 means all boards are done: writes are ignored
                        if (board_idx == 2'd0) begin
                            case (offset)
                                8'h4A: z2_base[3:0] <= cpu_din[15:12];
                                8'h48: begin
                                    z2_base[7:4] <= cpu_din[15:12];
                                    board_cfg[0] <= 1'b1;
                                    board_idx    <= board_idx + 2'd1;
                                    adv          <= 1'b1;
                                end
                                8'h4C: begin
                                    board_idx <= board_idx + 2'd1;
                                    adv       <= 1'b1;
                                end
                                default: ;
                            endcase
                        end else if (board_idx != 2'd3) begin
                            case (offset)
                                8'h44: begin
                                    if (board_idx == 2'd1) begin
                                        z3_base      <= cpu_din;
                                        board_cfg[1] <= 1'b1;
                                    end else begin
                                        eth_base     <= cpu_din;
                                        board_cfg[2] <= 1'b1;
                                    end
                                    board_idx <= board_idx + 2'd1;
                                    adv       <= 1'b1;
                                end
                                8'h4C: begin
                                    board_idx <= board_idx + 2'd1;
                                    adv       <= 1'b1;
                                end
                                default: ;
                            endcase
                        end
                    end else begin
                        dly <= dly + 2'd1;
                    end
                end
                ACK: begin
                    if (!cpu_sel) begin
                        if (adv)                    state <= SCAN;
                        else if (board_idx == 2'd3) state <= DONE;
                        else                        state <= IDLE;
                    end
                end
                default: state <= SCAN;
            endcase
        end
    end

endmodule

// File: tb/tb_minimig_autoconfig_ctrl.sv
// Bench for minimig_autoconfig_ctrl: reference model feeds a scoreboard
// queue, an ack monitor pops and compares.
module tb_minimig_autoconfig_ctrl;

    localparam int AD = 0;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [2:0]  board_en = 3'b111;
    logic        cpu_sel = 1'b0;
    logic        cpu_rd = 1'b0;
    logic        cpu_wr = 1'b0;
    logic [6:0]  cpu_addr = 7'h00;
    logic [15:0] cpu_din = 16'h0000;
    logic [15:0] cpu_dout;
    logic        cpu_ack;
    logic [7:0]  rom_addr;
    logic [3:0]  rom_q;
    logic [7:0]  z2_base;
    logic [15:0] z3_base;
    logic [15:0] eth_base;
    logic [2:0]  board_cfg;
    logic        config_done;

    minimig_autoconfig_ctrl #(.ACK_DELAY(AD)) dut (
        .clk(clk), .reset_n(reset_n), .board_en(board_en),
        .cpu_sel(cpu_sel), .cpu_rd(cpu_rd), .cpu_wr(cpu_wr),
        .cpu_addr(cpu_addr), .cpu_din(cpu_din), .cpu_dout(cpu_dout),
        .cpu_ack(cpu_ack), .rom_addr(rom_addr), .rom_q(rom_q),
        .z2_base(z2_base), .z3_base(z3_base), .eth_base(eth_base),
        .board_cfg(board_cfg), .config_done(config_done)
    );

    always #5 clk = ~clk;

    logic [3:0] rom [256];
    always_ff @(posedge clk) rom_q <= rom[rom_addr];

    int cyc = 0;
    always_ff @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit          rd;
        logic [15:0] dout;
        logic [7:0]  ra;
        logic [7:0]  z2;
        logic [15:0] z3;
        logic [15:0] eth;
        logic [2:0]  cfg;
        int          lat;
    } exp_t;

    exp_t sbq[$];
    int   passed = 0;
    int   total = 0;
    int   ack_cnt = 0;
    int   start_cyc = 0;

    // reference model state
    int          m_idx;
    logic [2:0]  m_en;
    logic [7:0]  m_z2;
    logic [15:0] m_z3, m_eth;
    logic [2:0]  m_cfg;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s actual=%h expected=%h", name, act, exp);
    endfunction

    always @(negedge clk) begin
        if (reset_n && cpu_ack) begin
            exp_t e;
            ack_cnt++;
            if (sbq.size() == 0) begin
                total++;
                $display("FAIL spurious_ack actual=1 expected=0 cyc=%0d", cyc);
            end else begin
                e = sbq.pop_front();
                chk("latency", 32'(cyc - start_cyc), 32'(e.lat));
                if (e.rd) begin
                    chk("cpu_dout", 32'(cpu_dout), 32'(e.dout));
                    chk("rom_addr", 32'(rom_addr), 32'(e.ra));
                end
                chk("z2_base", 32'(z2_base), 32'(e.z2));
                chk("z3_base", 32'(z3_base), 32'(e.z3));
                chk("eth_base", 32'(eth_base), 32'(e.eth));
                chk("board_cfg", 32'(board_cfg), 32'(e.cfg));
            end
        end
    end

    function automatic void m_scan();
        while (m_idx < 3 && !m_en[m_idx]) m_idx++;
    endfunction

    function automatic void m_reset(logic [2:0] en);
        m_en = en; m_idx = 0;
        m_z2 = 0; m_z3 = 0; m_eth = 0; m_cfg = 0;
        m_scan();
    endfunction

    function automatic exp_t m_access(bit rd, logic [6:0] a, logic [15:0] d);
        exp_t e;
        int   off;
        bit   advance;
        logic [7:0] ra;
        off = int'(a) * 2;
        advance = 0;
        ra = 8'((m_idx * 64) + (int'(a) % 64));
        e.rd = rd;
        e.ra = ra;
        e.dout = {rom[ra], 12'hFFF};
        e.lat = rd ? 3 + AD : 2 + AD;
        if (!rd && m_idx == 0) begin
            if (off == 'h4A) m_z2[3:0] = d[15:12];
            if (off == 'h48) begin m_z2[7:4] = d[15:12]; m_cfg[0] = 1; advance = 1; end
            if (off == 'h4C) advance = 1;
        end else if (!rd && m_idx < 3) begin
            if (off == 'h44) begin
                if (m_idx == 1) m_z3 = d; else m_eth = d;
                m_cfg[m_idx] = 1;
                advance = 1;
            end
            if (off == 'h4C) advance = 1;
        end
        if (advance) begin m_idx++; m_scan(); end
        e.z2 = m_z2; e.z3 = m_z3; e.eth = m_eth; e.cfg = m_cfg;
        return e;
    endfunction

    task automatic do_reset(input logic [2:0] en);
        cpu_sel = 0; cpu_rd = 0; cpu_wr = 0;
        board_en = en;
        reset_n = 0;
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        reset_n = 1;
        m_reset(en);
        chk("rst_dout", 32'(cpu_dout), 32'hFFFF);
        chk("rst_ack", 32'(cpu_ack), 0);
        chk("rst_bases", {z2_base, z3_base, eth_base[7:0]}, 0);
        chk("rst_cfg", 32'(board_cfg), 0);
        chk("rst_done", 32'(config_done), 32'(en == 3'b000));
        repeat (6) @(negedge clk); #1;
    endtask

    task automatic xact(input bit rd, input logic [6:0] a,
                        input logic [15:0] d, input int hold);
        int  n0;
        bit  got;
        sbq.push_back(m_access(rd, a, d));
        n0 = ack_cnt;
        got = 0;
        cpu_addr = a; cpu_din = d; cpu_rd = rd; cpu_wr = !rd;
        cpu_sel = 1;
        start_cyc = cyc;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk); #1;
            if (ack_cnt != n0) got = 1;
        end
        if (!got) begin
            total++;
            $display("FAIL ack_timeout actual=none expected=ack addr=%h", a);
            void'(sbq.pop_back());
        end
        repeat (hold) @(negedge clk);
        if (hold > 0) begin #1; chk("single_ack", 32'(ack_cnt - n0), 1); end
        cpu_sel = 0; cpu_rd = 0; cpu_wr = 0;
        repeat (6) @(negedge clk); #1;
        chk("config_done", 32'(config_done), 32'(m_idx == 3));
    endtask

    initial begin
        int n0;
        for (int i = 0; i < 256; i++) rom[i] = 4'($urandom);
        for (int i = 192; i < 256; i++) rom[i] = 4'hF;
        rom[8'h00] = 4'hE; rom[8'h08] = 4'hE; rom[8'h13] = 4'hE;
        rom[8'h40] = 4'hA; rom[8'h80] = 4'h8;

        do_reset(3'b111);
        xact(1, 7'h00, 16'h0, 0);
        chk("lit_rd00", 32'(cpu_dout), 32'hEFFF);
        xact(1, 7'h08, 16'h0, 0);
        chk("lit_ra10", 32'(rom_addr), 32'h08);
        xact(1, 7'h13, 16'h0, 0);
        chk("lit_ra26", 32'(rom_addr), 32'h13);
        xact(0, 7'h25, 16'h5000, 0);
        xact(0, 7'h24, 16'h2000, 0);
        chk("lit_z2", 32'(z2_base), 32'h25);
        xact(1, 7'h00, 16'h0, 0);
        chk("lit_z3rd", 32'(cpu_dout), 32'hAFFF);

        do_reset(3'b100);
        xact(1, 7'h00, 16'h0, 0);
        chk("lit_ethrd", 32'(cpu_dout), 32'h8FFF);
        xact(0, 7'h22, 16'h4001, 0);
        chk("lit_eth", 32'(eth_base), 32'h4001);
        chk("lit_done1", 32'(config_done), 1);

        do_reset(3'b011);
        xact(0, 7'h26, 16'h1234, 0);
        chk("lit_shutup", 32'(board_cfg), 0);
        xact(0, 7'h22, 16'h4000, 0);
        chk("lit_done2", 32'(config_done), 1);
        xact(1, 7'h00, 16'h0, 10);
        chk("lit_donerd", 32'(cpu_dout), 32'hFFFF);

        // reset while the read is in flight must abort it silently
        do_reset(3'b111);
        n0 = ack_cnt;
        cpu_addr = 7'h00; cpu_rd = 1; cpu_sel = 1;
        @(posedge clk); #1;
        reset_n = 0;
        #1;
        chk("abort_ack", 32'(cpu_ack), 0);
        chk("abort_dout", 32'(cpu_dout), 32'hFFFF);
        cpu_sel = 0; cpu_rd = 0;
        repeat (2) @(negedge clk);
        #1 reset_n = 1;
        m_reset(3'b111);
        repeat (8) @(negedge clk); #1;
        chk("abort_noack", 32'(ack_cnt - n0), 0);
        xact(1, 7'h00, 16'h0, 0);

        for (int r = 0; r < 6; r++) begin
            do_reset(3'($urandom));
            for (int t = 0; t < 25; t++) begin
                logic [6:0] a;
                case ($urandom % 6)
                    0: a = 7'h22;
                    1: a = 7'h24;
                    2: a = 7'h25;
                    3: a = 7'h26;
                    default: a = 7'($urandom);
                endcase
                xact(1'($urandom), a, 16'($urandom), 0);
            end
        end

        chk("sb_empty", 32'(sbq.size()), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
